serial_operand_serializer: RTL and testbench

Upstream feeder for the bit-serial adder datapath. It accepts pairs of WIDTH-bit operands over a valid/ready handshake and shifts both out LSB-first, one bit per clock. In the same stream it drives `bit_valid`, `last` and `carry_clr`. `carry_clr` connects straight to the serial adder's synchronous carry-reset input, so every word is summed with carry-in 0. A one-entry pending buffer lets back-to-back words stream with no bubble between them.

---
 rtl/serial_pkg.sv | 13 +
 rtl/serial_operand_serializer.sv | 123 ++++++++++++
 tb/tb_serial_operand_serializer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg : shared types for the bit-serial adder operand feeder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package serial_pkg;

  typedef enum logic {IDLE, SHIFT} ser_state_t;

endpackage : serial_pkg

`default_nettype wire

// File: rtl/serial_operand_serializer.sv
// ---------------------------------------------------------------------------
// serial_operand_serializer : shifts operand pairs out LSB-first with a
// one-entry pending buffer for bubble-free streaming.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_operand_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             a,
  output logic             b,
  output logic             bit_valid,
  output logic             last,
  output logic             carry_clr
);

  localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(WIDTH - 1);

  ser_state_t         r_state, w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_sh_a, r_sh_b, w_sh_a_nxt, w_sh_b_nxt;
  logic [WIDTH-1:0]   r_pend_a, r_pend_b, w_pend_a_nxt, w_pend_b_nxt;
  logic               r_pend_v, w_pend_v_nxt;
  logic               w_xfer;
  logic               w_last_bit;

  // in_ready depends only on registered state, never on in_valid
  assign w_xfer     = in_valid & ~r_pend_v;
  assign w_last_bit = (r_state == SHIFT) && (r_cnt == c_LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_sh_a   <= '0;
      r_sh_b   <= '0;
      r_pend_a <= '0;
      r_pend_b <= '0;
      r_pend_v <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sh_a   <= w_sh_a_nxt;
      r_sh_b   <= w_sh_b_nxt;
      r_pend_a <= w_pend_a_nxt;
      r_pend_b <= w_pend_b_nxt;
      r_pend_v <= w_pend_v_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_sh_a_nxt   = r_sh_a;
    w_sh_b_nxt   = r_sh_b;
    w_pend_a_nxt = r_pend_a;
    w_pend_b_nxt = r_pend_b;
    w_pend_v_nxt = r_pend_v;

    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          w_state_nxt = SHIFT;
          w_sh_a_nxt  = in_a;
          w_sh_b_nxt  = in_b;
          w_cnt_nxt   = '0;
        end
      end

      SHIFT: begin
        if (w_last_bit) begin
          // pending word wins; a transfer cannot coincide since in_ready is low
          w_cnt_nxt = '0;
          if (r_pend_v) begin
            w_sh_a_nxt   = r_pend_a;
            w_sh_b_nxt   = r_pend_b;
            w_pend_v_nxt = 1'b0;
          end else if (w_xfer) begin
            w_sh_a_nxt = in_a;
            w_sh_b_nxt = in_b;
          end else begin
            w_state_nxt = IDLE;
            w_sh_a_nxt  = {1'b0, r_sh_a[WIDTH-1:1]};
            w_sh_b_nxt  = {1'b0, r_sh_b[WIDTH-1:1]};
          end
        end else begin
          w_sh_a_nxt = {1'b0, r_sh_a[WIDTH-1:1]};
          w_sh_b_nxt = {1'b0, r_sh_b[WIDTH-1:1]};
          w_cnt_nxt  = r_cnt + c_CNT_W'(1);
          if (w_xfer) begin
            w_pend_a_nxt = in_a;
            w_pend_b_nxt = in_b;
            w_pend_v_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign in_ready  = ~r_pend_v;
  assign bit_valid = (r_state == SHIFT);
  assign last      = bit_valid & (r_cnt == c_LAST_CNT);
  // holds the adder carry at 0 while idle and drops each word's carry-out
  assign carry_clr = ~bit_valid | last;
  assign a         = bit_valid & r_sh_a[0];
  assign b         = bit_valid & r_sh_b[0];

endmodule : serial_operand_serializer

`default_nettype wire

// File: tb/tb_serial_operand_serializer.sv
// ---------------------------------------------------------------------------
// tb_serial_operand_serializer : word-queue reference model plus a serial
// adder stand-in that sums the streamed bits.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_serial_operand_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_ready, a, b, bit_valid, last, carry_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_operand_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .a         (a),
    .b         (b),
    .bit_valid (bit_valid),
    .last      (last),
    .carry_clr (carry_clr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: accepted words queued in order; the head streams one bit per cycle
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  int           m_idx = 0;
  bit           m_go;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qa.delete();
      qb.delete();
      m_idx = 0;
    end else begin
      m_go = in_valid && (qa.size() < 2);
      if (qa.size() > 0) begin
        m_idx++;
        if (m_idx == W) begin
          void'(qa.pop_front());
          void'(qb.pop_front());
          m_idx = 0;
        end
      end
      if (m_go) begin
        qa.push_back(in_a);
        qb.push_back(in_b);
      end
    end
  end

  // Serial adder stand-in with synchronous carry clear
  logic c_reg = 1'b0;
  always @(posedge clk) begin
    if (carry_clr) c_reg <= 1'b0;
    else           c_reg <= (a & b) | (a & c_reg) | (b & c_reg);
  end

  logic [W-1:0] sums[$];
  logic         abits[$];
  logic         bbits[$];
  int           runs[$];
  int           cur_run = 0;
  logic [W-1:0] acc = '0;
  logic [W-1:0] exp_sum;
  logic         exp_bv, exp_last, exp_a, exp_b;

  always @(negedge clk) begin
    exp_bv   = (qa.size() > 0);
    exp_last = exp_bv && (m_idx == W - 1);
    exp_a    = 1'b0;
    exp_b    = 1'b0;
    if (exp_bv) begin
      exp_a = qa[0][m_idx];
      exp_b = qb[0][m_idx];
    end
    chk("bit_valid", 32'(bit_valid), 32'(exp_bv));
    chk("last",      32'(last),      32'(exp_last));
    chk("a",         32'(a),         32'(exp_a));
    chk("b",         32'(b),         32'(exp_b));
    chk("carry_clr", 32'(carry_clr), 32'(!exp_bv || exp_last));
    chk("in_ready",  32'(in_ready),  32'(qa.size() < 2));
    if (bit_valid && exp_bv) begin
      acc[m_idx] = a ^ b ^ c_reg;
      abits.push_back(a);
      bbits.push_back(b);
      if (m_idx == W - 1) begin
        exp_sum = qa[0] + qb[0];
        chk("sum", 32'(acc), 32'(exp_sum));
        sums.push_back(acc);
      end
    end
    if (bit_valid) cur_run++;
    else if (cur_run > 0) begin
      runs.push_back(cur_run);
      cur_run = 0;
    end
  end

  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb);
    logic got;
    bit   done;
    int   t;
    done     = 1'b0;
    t        = 0;
    in_valid = 1'b1;
    in_a     = xa;
    in_b     = xb;
    while (!done && t < 64) begin
      got = in_ready;
      @(posedge clk);
      #1;
      if (got) done = 1'b1;
      t++;
    end
    if (!done) chk("send_timeout", 32'(0), 32'(1));
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] sum_at(input int back);
    if (sums.size() > back) return 32'(sums[sums.size() - 1 - back]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] last_run();
    if (runs.size() > 0) return 32'(runs[runs.size() - 1]);
    return 32'hFFFF_FFFF;
  endfunction

  int  n0;
  bit  prev_go;
  logic [3:0] seq_a, seq_b;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bit_valid", 32'(bit_valid), 32'(0));
    chk("rst_carry_clr", 32'(carry_clr), 32'(1));
    chk("rst_in_ready",  32'(in_ready),  32'(1));
    chk("rst_a",         32'(a),         32'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(in_ready),  32'(1));
    chk("post_rst_cclr",  32'(carry_clr), 32'(1));

    // Single word: 1011 + 0110 = 17 mod 16 = 1
    n0 = abits.size();
    send(4'b1011, 4'b0110);
    repeat (6) @(posedge clk);
    #1;
    chk("single_nbits", 32'(abits.size() - n0), 32'(4));
    if (abits.size() >= n0 + 4) begin
      seq_a = {abits[n0+3], abits[n0+2], abits[n0+1], abits[n0]};
      seq_b = {bbits[n0+3], bbits[n0+2], bbits[n0+1], bbits[n0]};
      chk("single_a_seq", 32'(seq_a), 32'(4'b1011));
      chk("single_b_seq", 32'(seq_b), 32'(4'b0110));
    end
    chk("single_sum", sum_at(0), 32'(1));

    // Back-to-back with a held third word under backpressure
    send(4'hF, 4'h1);
    send(4'h3, 4'h4);
    send(4'h5, 4'h6);
    repeat (16) @(posedge clk);
    #1;
    chk("b2b_sum0", sum_at(2), 32'(0));
    chk("b2b_sum1", sum_at(1), 32'(7));
    chk("b2b_sum2", sum_at(0), 32'(11));
    chk("b2b_run",  last_run(), 32'(12));

    // Bypass: second word first offered in the last-bit cycle
    send(4'h2, 4'h3);
    for (int t = 0; t < 20 && !last; t++) begin
      @(posedge clk);
      #1;
    end
    chk("bypass_at_last", 32'(last), 32'(1));
    chk("bypass_ready",   32'(in_ready), 32'(1));
    send(4'h9, 4'h9);
    repeat (8) @(posedge clk);
    #1;
    chk("bypass_sum0", sum_at(1), 32'(5));
    chk("bypass_sum1", sum_at(0), 32'(2));
    chk("bypass_run",  last_run(), 32'(8));

    // Mid-word reset with a pending word
    send(4'h7, 4'h7);
    send(4'h1, 4'h1);
    for (int t = 0; t < 20 && !(m_idx == 2 && qa.size() == 2); t++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_pending", 32'(in_ready), 32'(0));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_bv",    32'(bit_valid), 32'(0));
    chk("mid_rst_last",  32'(last),      32'(0));
    chk("mid_rst_a",     32'(a),         32'(0));
    chk("mid_rst_b",     32'(b),         32'(0));
    chk("mid_rst_cclr",  32'(carry_clr), 32'(1));
    chk("mid_rst_ready", 32'(in_ready),  32'(1));
    n0 = sums.size();
    @(posedge clk);
    #1 rst = 1'b0;
    send(4'h6, 4'h5);
    repeat (6) @(posedge clk);
    #1;
    chk("mid_nwords", 32'(sums.size() - n0), 32'(1));
    chk("mid_sum",    sum_at(0), 32'(11));

    // Randomized traffic with held data under backpressure and rare resets
    prev_go  = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || prev_go) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_a     = W'($urandom);
        in_b     = W'($urandom);
      end
      if ($urandom_range(0, 99) == 0) begin
        in_valid = 1'b0;
        prev_go  = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
      end else begin
        prev_go = in_valid && in_ready;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule : tb_serial_operand_serializer

`default_nettype wire
